// File: rtl/clock_divider_prog.sv
// rtl/clock_divider_prog.sv - runtime-programmable clock divider with shadowed config
// Period/high-time load over valid/ready and take effect only at a period boundary.
module clock_divider_prog #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DEFAULT_DIV  = 2,
  parameter int unsigned DEFAULT_HIGH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] div_in,
  input  logic [CNT_W-1:0] high_in,
  output logic             cfg_applied,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_DIV  = CNT_W'(2);
  localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(DEFAULT_HIGH);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] high_act;
  logic [CNT_W-1:0] div_sh;
  logic [CNT_W-1:0] high_sh;
  logic             pend;

  logic             last;
  logic             accept;
  logic             div_ok;
  logic             apply;

  assign last      = (cnt == (div_act - ONE));
  assign cfg_ready = ~pend;
  assign accept    = cfg_valid & ~pend;
  assign div_ok    = (div_in >= MIN_DIV);
  // With en low there is no boundary to wait for, so a pending config lands at once.
  assign apply     = pend & (~en | last);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      div_act     <= RST_DIV;
      high_act    <= RST_HIGH;
      div_sh      <= '0;
      high_sh     <= '0;
      pend        <= 1'b0;
      clk_out     <= 1'b0;
      tick        <= 1'b0;
      cfg_applied <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      // Outputs are computed from the pre-edge count, so the old period's tick survives an apply.
      clk_out     <= en & (cnt < high_act);
      tick        <= en & last;
      cfg_applied <= apply;
      cfg_err     <= accept & ~div_ok;

      if (apply) begin
        div_act  <= div_sh;
        high_act <= high_sh;
        cnt      <= '0;
        pend     <= 1'b0;
      end else begin
        if (en) begin
          cnt <= last ? '0 : (cnt + ONE);
        end
        if (accept && div_ok) begin
          div_sh  <= div_in;
          high_sh <= high_in;
          pend    <= 1'b1;
        end
      end
    end
  end

endmodule
